// File: rtl/seq_feed_ctrl.sv
// Word-to-bit front end for a serial sequence detector: serializes words MSB-first,
// realigns the detector's response to the fed bits and keeps per-word and total hit status.
module seq_feed_ctrl #(
  parameter int   WORD_W   = 8,
  parameter int   CNT_W    = 16,
  parameter int   DET_LAT  = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  input  logic              flush,
  output logic              seq_out,
  output logic              seq_valid,
  input  logic              det_in,
  output logic [CNT_W-1:0]  match_count,
  output logic              word_done,
  output logic              word_hit,
  output logic              busy
);

  localparam int BC_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nx;
  logic [WORD_W-1:0]   shreg, shreg_nx;
  logic [BC_W-1:0]     bit_cnt, bit_cnt_nx;
  logic                seq_out_nx, seq_valid_nx;
  logic                seq_last, seq_last_nx;
  logic                accept;

  logic [DET_LAT-1:0]  vld_pipe, last_pipe;
  logic                dly_valid, dly_last, cnt_en, sticky;

  // bit_cnt counts the bits still to be driven after the one currently on seq_out.
  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    bit_cnt_nx   = bit_cnt;
    seq_out_nx   = IDLE_BIT;
    seq_valid_nx = 1'b0;
    seq_last_nx  = 1'b0;
    in_ready     = 1'b0;

    case (state)
      IDLE:    in_ready = enable;
      SHIFT:   in_ready = enable && (bit_cnt == '0);
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & reset;
    accept   = in_valid & in_ready;

    if (accept) begin
      state_nx     = SHIFT;
      shreg_nx     = in_data << 1;
      bit_cnt_nx   = BC_W'(WORD_W - 1);
      seq_out_nx   = in_data[WORD_W-1];
      seq_valid_nx = 1'b1;
    end else if (state == SHIFT) begin
      if (bit_cnt == '0) begin
        state_nx = IDLE;
      end else if (enable) begin
        seq_out_nx   = shreg[WORD_W-1];
        seq_valid_nx = 1'b1;
        seq_last_nx  = (bit_cnt == BC_W'(1));
        shreg_nx     = shreg << 1;
        bit_cnt_nx   = bit_cnt - BC_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      seq_out   <= IDLE_BIT;
      seq_valid <= 1'b0;
      seq_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      seq_out   <= seq_out_nx;
      seq_valid <= seq_valid_nx;
      seq_last  <= seq_last_nx;
    end
  end

  // Delay valid and last-bit tags so they line up with the detector's response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= seq_valid;
      last_pipe[0] <= seq_valid & seq_last;
      for (int i = 1; i < DET_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign dly_valid = vld_pipe[DET_LAT-1];
  assign dly_last  = last_pipe[DET_LAT-1];
  assign cnt_en    = dly_valid & det_in;
  assign word_done = dly_last;
  assign word_hit  = dly_last & (sticky | cnt_en);
  assign busy      = (state == SHIFT) | (|vld_pipe);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky      <= 1'b0;
      match_count <= '0;
    end else begin
      if (word_done)   sticky <= 1'b0;
      else if (cnt_en) sticky <= 1'b1;

      if (flush)
        match_count <= '0;
      else if (cnt_en && (match_count != {CNT_W{1'b1}}))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl: directed scenarios plus random traffic, all checked each cycle
// against a queue-based bit-stream model feeding a 1011 detector model.
module tb_seq_feed_ctrl;

  localparam int WORD_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [WORD_W-1:0] in_data;
  logic              in_valid, enable, flush;
  logic              in_ready, seq_out, seq_valid, det_in, word_done, word_hit, busy;
  logic [15:0]       match_count;
  logic              in_ready2, seq_out2, seq_valid2, det_in2, word_done2, word_hit2, busy2;
  logic [1:0]        match_count2;

  always #5 clock = ~clock;

  seq_feed_ctrl #(.WORD_W(WORD_W), .CNT_W(16), .DET_LAT(1), .IDLE_BIT(1'b0)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .enable(enable), .flush(flush), .seq_out(seq_out),
    .seq_valid(seq_valid), .det_in(det_in), .match_count(match_count),
    .word_done(word_done), .word_hit(word_hit), .busy(busy)
  );

  seq_feed_ctrl #(.WORD_W(WORD_W), .CNT_W(2), .DET_LAT(1), .IDLE_BIT(1'b0)) dut2 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .enable(enable), .flush(flush), .seq_out(seq_out2),
    .seq_valid(seq_valid2), .det_in(det_in2), .match_count(match_count2),
    .word_done(word_done2), .word_hit(word_hit2), .busy(busy2)
  );

  // Behavioural 1011 overlapping Moore detectors, one per instance, never reset.
  logic [3:0] dh1 = 4'b0000;
  logic [3:0] dh2 = 4'b0000;
  always @(posedge clock) begin
    dh1 <= {dh1[2:0], seq_out};
    dh2 <= {dh2[2:0], seq_out2};
  end
  assign det_in  = (dh1 == 4'b1011);
  assign det_in2 = (dh2 == 4'b1011);

  // Reference model state: bits queued but not yet driven, the bit on the line,
  // the one-cycle-delayed view of it, and the detector's own history.
  bit          q[$];
  bit          m_out, m_valid, m_last, dv, dl, sticky, m_det;
  logic [3:0]  m_hist;
  int unsigned cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, acc_cyc = 0, last_done_cyc = 0;
  int n_done_seen = 0, n_hit_seen = 0, run = 0, max_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_out = 0; m_valid = 0; m_last = 0; dv = 0; dl = 0; sticky = 0;
    m_det = 0; m_hist = 4'b0000; cnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit acc, input logic [WORD_W-1:0] data, input bit fl);
    bit cen;
    bit wd;
    cen    = dv && m_det;
    wd     = dl;
    m_hist = {m_hist[2:0], m_out};
    m_det  = (m_hist == 4'b1011);
    if (wd)       sticky = 0;
    else if (cen) sticky = 1;
    if (fl)       cnt = 0;
    else if (cen) cnt++;
    dv = m_valid;
    dl = m_valid && m_last;
    m_out = 0; m_valid = 0; m_last = 0;
    if (en) begin
      if (acc)
        for (int i = WORD_W - 1; i >= 0; i--) q.push_back(data[i]);
      if (q.size() > 0) begin
        m_out   = q.pop_front();
        m_valid = 1;
        m_last  = (q.size() == 0);
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs at the next falling edge.
  task automatic cycle(input bit en, input bit vld, input logic [WORD_W-1:0] data,
                       input bit fl, output bit acc);
    enable = en; in_valid = vld; in_data = data; flush = fl;
    #1;
    acc = en && (q.size() == 0) && vld;
    check("in_ready", in_ready, en && (q.size() == 0));
    @(posedge clock);
    model_edge(en, acc, data, fl);
    cyc++;
    @(negedge clock);
    check("seq_out", seq_out, m_out);
    check("seq_valid", seq_valid, m_valid);
    check("seq_out2", seq_out2, m_out);
    check("busy", busy, (q.size() > 0) || m_valid || dv);
    check("word_done", word_done, dl);
    check("word_hit", word_hit, dl && (sticky || (dv && m_det)));
    check("match_count", match_count, (cnt > 65535) ? 65535 : cnt);
    check("match_count2", match_count2, (cnt > 3) ? 3 : cnt);
    if (word_done) begin
      n_done_seen++;
      last_done_cyc = cyc;
      if (word_hit) n_hit_seen++;
    end
    run     = seq_valid ? run + 1 : 0;
    max_run = (run > max_run) ? run : max_run;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, acc);
  endtask

  task automatic send(input logic [WORD_W-1:0] d);
    bit acc;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) cycle(1, 1, d, 0, acc);
    check("send_accepted", acc, 1);
    acc_cyc = cyc;
  endtask

  task automatic reset_mid(input int n);
    #2 reset = 1'b0;
    #1;
    check("rst_seq_out", seq_out, 0);
    check("rst_seq_valid", seq_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_word_done", word_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_match_count", match_count, 0);
    enable = 1; in_valid = 0; flush = 0;
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  int  base_done, base_hit;
  bit  acc, fl, found;

  initial begin
    enable = 1; in_valid = 0; in_data = '0; flush = 0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check("init_in_ready_in_reset", in_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("init_in_ready", in_ready, 1);
    check("init_seq_valid", seq_valid, 0);
    check("init_match_count", match_count, 0);
    idle(2);

    // Back-to-back 0xAD, 0x6C: 16-bit run, two hit words, three matches.
    base_done = n_done_seen; base_hit = n_hit_seen; max_run = 0;
    send(8'hAD);
    send(8'h6C);
    idle(12);
    check("t3_done_pulses", n_done_seen - base_done, 2);
    check("t3_hit_pulses", n_hit_seen - base_hit, 2);
    check("t3_max_run", max_run, 16);
    check("t3_count", match_count, 3);

    // All-zero word: done without hit, count unchanged, 8-cycle latency.
    base_done = n_done_seen; base_hit = n_hit_seen;
    send(8'h00);
    idle(12);
    check("t4_done_pulses", n_done_seen - base_done, 1);
    check("t4_hit_pulses", n_hit_seen - base_hit, 0);
    check("t4_count", match_count, 3);
    check("t4_latency", last_done_cyc - acc_cyc, 8);

    // Four-cycle pause mid-word pushes word_done out by four cycles.
    send(8'hAD);
    cycle(1, 0, '0, 0, acc);
    cycle(1, 0, '0, 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, acc);
    idle(14);
    check("t5_latency", last_done_cyc - acc_cyc, 12);

    // Saturation on the 2-bit counter, then flush coinciding with a counted hit.
    send(8'hBB); send(8'hBB); send(8'hBB);
    idle(12);
    check("t6_saturated", match_count2, 3);
    send(8'hBB);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      fl = !found && dv && m_det;
      cycle(1, 0, '0, fl, acc);
      if (fl) begin
        found = 1;
        check("t6_flush_cnt2", match_count2, 0);
        check("t6_flush_cnt", match_count, 0);
      end
    end
    check("t6_flush_found", found, 1);

    // Reset in the middle of a word: no word_done for the discarded word.
    send(8'hFF);
    cycle(1, 0, '0, 0, acc);
    cycle(1, 0, '0, 0, acc);
    base_done = n_done_seen;
    reset_mid(4);
    idle(12);
    check("t2_no_done_after_reset", n_done_seen - base_done, 0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            WORD_W'($urandom), $urandom_range(0, 49) == 0, acc);
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
